// File: rtl/video_pattern_gen_pkg.sv
// Shared definitions for the video pattern generator.
//  - pattern mode encodings (PAT_BARS..PAT_GRID); codes 5-7 are reserved and render black
//  - colour-bar table as on/off masks {R,G,B}; every entry is full-scale or zero
package video_pattern_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    PAT_BARS  = 3'd0,
    PAT_SOLID = 3'd1,
    PAT_GRAD  = 3'd2,
    PAT_CHECK = 3'd3,
    PAT_GRID  = 3'd4
  } pat_mode_t;

  // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_mask(input logic [2:0] idx);
    logic [2:0] m;
    case (idx)
      3'd0:    m = 3'b111;
      3'd1:    m = 3'b110;
      3'd2:    m = 3'b011;
      3'd3:    m = 3'b010;
      3'd4:    m = 3'b101;
      3'd5:    m = 3'b100;
      3'd6:    m = 3'b001;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Video output bus of the pattern generator.
//  hs/vs/de        sync and data enable
//  rgb_r/g/b       pixel colour, 0 outside the active area
//  active_x/y      pixel column/row while de=1
//  frame_start     1-cycle pulse with pixel (0,0)
//  frame_cnt       completed-frame count
//  mode_active     pattern mode currently rendered
// master: the generator; slave: the consumer (encoder).
interface video_pattern_gen_if #(
  parameter int unsigned CNT_W   = 12,
  parameter int unsigned COLOR_W = 8
);
  import video_pattern_pkg::*;

  logic               hs;
  logic               vs;
  logic               de;
  logic [COLOR_W-1:0] rgb_r;
  logic [COLOR_W-1:0] rgb_g;
  logic [COLOR_W-1:0] rgb_b;
  logic [CNT_W-1:0]   active_x;
  logic [CNT_W-1:0]   active_y;
  logic               frame_start;
  logic [15:0]        frame_cnt;
  logic [MODE_W-1:0]  mode_active;

  modport master (
    output hs, vs, de, rgb_r, rgb_g, rgb_b, active_x, active_y,
           frame_start, frame_cnt, mode_active
  );

  modport slave (
    input  hs, vs, de, rgb_r, rgb_g, rgb_b, active_x, active_y,
           frame_start, frame_cnt, mode_active
  );

endinterface

// File: rtl/video_pattern_gen_timing_core.sv
// Raster timing core: h/v counters plus combinational decode of the
// current counter state (hs/vs/de, line end, frame boundary, first pixel).
// Ports: clk, rst (async, active high); h_cnt/v_cnt counter state;
//        hs/vs/de decoded sync/enable; line_end (h_cnt wrap);
//        frame_end (last pixel of frame); frame_first (pixel (0,0)).
module video_timing_core #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic             line_end,
  output logic             frame_end,
  output logic             frame_first
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= frame_end ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    line_end    = (h_cnt == CNT_W'(H_TOTAL - 1));
    frame_end   = line_end && (v_cnt == CNT_W'(V_TOTAL - 1));
    frame_first = (h_cnt == '0) && (v_cnt == '0);
    de          = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
    hs          = ((h_cnt >= CNT_W'(HS_BEG)) && (h_cnt < CNT_W'(HS_END))) ? HS_POL : ~HS_POL;
    vs          = ((v_cnt >= CNT_W'(VS_BEG)) && (v_cnt < CNT_W'(VS_END))) ? VS_POL : ~VS_POL;
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Video timing generator with runtime-selectable test patterns.
// Ports: clk pixel clock; rst async active-high reset;
//        mode requested pattern, solid_rgb {R,G,B} for solid mode -- both
//        sampled only at the frame boundary;
//        vid (master) registered video output bus.
// Output edge n after reset release shows counter state n-1, so the first
// edge presents pixel (0,0).
module video_pattern_gen
  import video_pattern_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FP       = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BP       = 88,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BP       = 23,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned COLOR_W    = 8,
  parameter int unsigned CHECK_LOG2 = 5,
  parameter int unsigned GRID_LOG2  = 6,
  parameter int unsigned GRAD_SHIFT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MODE_W-1:0]      mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  video_pattern_gen_if.master    vid
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [CNT_W-1:0]     h_cnt, v_cnt;
  logic                 t_hs, t_vs, t_de, line_end, frame_end, frame_first;
  logic [CNT_W-1:0]     bar_pix;
  logic [2:0]           bar_idx;
  logic [MODE_W-1:0]    mode_q;
  logic [3*COLOR_W-1:0] solid_q;
  logic [15:0]          frame_cnt_q;
  logic [COLOR_W-1:0]   pix_r, pix_g, pix_b, grad;
  logic [2:0]           bar_rgb;

  video_timing_core #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HS_POL   (HS_POL),   .VS_POL (VS_POL), .CNT_W (CNT_W)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .hs          (t_hs),
    .vs          (t_vs),
    .de          (t_de),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .frame_first (frame_first)
  );

  // Bar position tracks h_cnt; the index saturates at the black bar so the
  // H_ACTIVE%8 remainder pixels (and blanking) stay black.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (line_end) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (bar_pix == CNT_W'(BAR_W - 1)) begin
      bar_pix <= '0;
      if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_pix <= bar_pix + CNT_W'(1);
    end
  end

  // Mode/colour latch and frame counter advance on the last pixel of a frame,
  // so the new pattern starts exactly at the following pixel (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= '0;
      solid_q     <= '0;
      frame_cnt_q <= '0;
    end else if (frame_end) begin
      mode_q      <= mode;
      solid_q     <= solid_rgb;
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  always_comb begin
    pix_r   = '0;
    pix_g   = '0;
    pix_b   = '0;
    bar_rgb = bar_mask(bar_idx);
    grad    = COLOR_W'(8'(h_cnt >> GRAD_SHIFT)) << (COLOR_W - 8);
    if (t_de) begin
      case (mode_q)
        PAT_BARS: begin
          pix_r = {COLOR_W{bar_rgb[2]}};
          pix_g = {COLOR_W{bar_rgb[1]}};
          pix_b = {COLOR_W{bar_rgb[0]}};
        end
        PAT_SOLID: {pix_r, pix_g, pix_b} = solid_q;
        PAT_GRAD: begin
          pix_r = grad;
          pix_g = grad;
          pix_b = grad;
        end
        PAT_CHECK: begin
          if (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) begin
            pix_r = '1;
            pix_g = '1;
            pix_b = '1;
          end
        end
        PAT_GRID: begin
          if ((h_cnt[GRID_LOG2-1:0] == '0) || (v_cnt[GRID_LOG2-1:0] == '0) ||
              (h_cnt == CNT_W'(H_ACTIVE - 1)) || (v_cnt == CNT_W'(V_ACTIVE - 1))) begin
            pix_r = '1;
            pix_g = '1;
            pix_b = '1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vid.hs          <= ~HS_POL;
      vid.vs          <= ~VS_POL;
      vid.de          <= 1'b0;
      vid.rgb_r       <= '0;
      vid.rgb_g       <= '0;
      vid.rgb_b       <= '0;
      vid.active_x    <= '0;
      vid.active_y    <= '0;
      vid.frame_start <= 1'b0;
      vid.frame_cnt   <= '0;
      vid.mode_active <= '0;
    end else begin
      vid.hs          <= t_hs;
      vid.vs          <= t_vs;
      vid.de          <= t_de;
      vid.rgb_r       <= pix_r;
      vid.rgb_g       <= pix_g;
      vid.rgb_b       <= pix_b;
      vid.active_x    <= t_de ? h_cnt : '0;
      vid.active_y    <= t_de ? v_cnt : '0;
      vid.frame_start <= frame_first;
      vid.frame_cnt   <= frame_cnt_q;
      vid.mode_active <= mode_q;
    end
  end

endmodule
